// File: rtl/instr_cache_2way.sv
// instr_cache_2way
//   Two-way set-associative, read-only instruction cache for the fetch stage.
//   Each set keeps one LRU bit. Lookup is combinational and uses the virtual
//   index and offset together with the physical tag from the TLB. A miss
//   latches the index, tag and victim way, then holds a registered refill
//   request to the memory arbiter until the line returns. Flush invalidates
//   every line and aborts a refill that is still outstanding.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   petFromProc       fetch request valid
//   virt_address      word address; [OFF+IDX-1:OFF] = index, [OFF-1:0] = offset
//   phys_tag          translated tag
//   flush             invalidate all lines
//   memServiceReady   dataReadFromMem is valid this cycle
//   dataReadFromMem   refill line
//   instructionBits   selected word of the hitting way, 0 when there is no hit
//   isHit             combinational lookup hit
//   addrToArb         {latched tag, latched index, OFF zeros}
//   petitionToArb     registered refill request
//   busy              refill outstanding (MISS state)
//   missCount         saturating miss counter
module instr_cache_2way #(
  parameter int cache_line_width = 256,
  parameter int word_width       = 16,
  parameter int addr_width       = 16,
  parameter int num_sets         = 4,
  parameter int cnt_width        = 16,
  localparam int WORDS = cache_line_width / word_width,
  localparam int OFF   = $clog2(WORDS),
  localparam int IDX   = $clog2(num_sets),
  localparam int TAG   = addr_width - OFF - IDX
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        petFromProc,
  input  logic [addr_width-1:0]       virt_address,
  input  logic [TAG-1:0]              phys_tag,
  input  logic                        flush,
  input  logic                        memServiceReady,
  input  logic [cache_line_width-1:0] dataReadFromMem,
  output logic [word_width-1:0]       instructionBits,
  output logic                        isHit,
  output logic [addr_width-1:0]       addrToArb,
  output logic                        petitionToArb,
  output logic                        busy,
  output logic [cnt_width-1:0]        missCount
);

  typedef enum logic {IDLE, MISS} cacheStateT;

  cacheStateT state, stateNext;

  logic [cache_line_width-1:0] data0 [num_sets];
  logic [cache_line_width-1:0] data1 [num_sets];
  logic [TAG-1:0]              tag0  [num_sets];
  logic [TAG-1:0]              tag1  [num_sets];
  logic [num_sets-1:0]         valid0, valid1;
  logic [num_sets-1:0]         lru;

  logic [IDX-1:0] latchIdx;
  logic [TAG-1:0] latchTag;
  logic           latchVictim;

  logic [IDX-1:0] idx;
  logic [OFF-1:0] off;
  logic           hit0, hit1;
  logic           victimNext;
  logic [cache_line_width-1:0] hitLine;
  logic [word_width-1:0]       hitWord;
  logic           startMiss, doFill, hitUpdate;
  logic           unusedAddrBits;

  assign idx = virt_address[OFF+IDX-1:OFF];
  assign off = virt_address[OFF-1:0];
  assign unusedAddrBits = ^virt_address[addr_width-1:OFF+IDX];

  // Lookup
  assign hit0  = !reset && valid0[idx] && (tag0[idx] == phys_tag);
  assign hit1  = !reset && valid1[idx] && (tag1[idx] == phys_tag);
  assign isHit = hit0 | hit1;

  // Way 0 wins if both ever match.
  assign hitLine = hit0 ? data0[idx] : data1[idx];

  always_comb begin
    hitWord = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (off == w[OFF-1:0]) hitWord = hitLine[w*word_width +: word_width];
    end
  end

  assign instructionBits = isHit ? hitWord : '0;

  // Prefer an empty way; only evict by LRU when both ways are valid.
  assign victimNext = !valid0[idx] ? 1'b0 :
                      !valid1[idx] ? 1'b1 : lru[idx];

  assign addrToArb = {latchTag, latchIdx, {OFF{1'b0}}};
  assign busy      = (state == MISS);

  // Next-state logic
  always_comb begin
    stateNext = state;
    startMiss = 1'b0;
    doFill    = 1'b0;
    hitUpdate = 1'b0;
    case (state)
      IDLE: begin
        if (petFromProc && !flush) begin
          if (isHit) begin
            hitUpdate = 1'b1;
          end else begin
            startMiss = 1'b1;
            stateNext = MISS;
          end
        end
      end
      MISS: begin
        if (flush) begin
          stateNext = IDLE;
        end else if (memServiceReady) begin
          doFill    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Control state: valid/LRU bits, miss latches, request and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid0        <= '0;
      valid1        <= '0;
      lru           <= '0;
      latchIdx      <= '0;
      latchTag      <= '0;
      latchVictim   <= 1'b0;
      petitionToArb <= 1'b0;
      missCount     <= '0;
    end else begin
      petitionToArb <= (stateNext == MISS);
      if (flush) begin
        valid0 <= '0;
        valid1 <= '0;
        lru    <= '0;
      end else begin
        // A hit on way 0 makes way 1 least recently used, and vice versa.
        if (hitUpdate) lru[idx] <= hit0;
        if (startMiss) begin
          latchIdx    <= idx;
          latchTag    <= phys_tag;
          latchVictim <= victimNext;
          if (missCount != '1) missCount <= missCount + {{(cnt_width-1){1'b0}}, 1'b1};
        end
        if (doFill) begin
          if (latchVictim) valid1[latchIdx] <= 1'b1;
          else             valid0[latchIdx] <= 1'b1;
          lru[latchIdx] <= ~latchVictim;
        end
      end
    end
  end

  // Line and tag storage; guarded by the valid bits, so no reset is needed.
  always_ff @(posedge clk) begin
    if (doFill) begin
      if (latchVictim) begin
        data1[latchIdx] <= dataReadFromMem;
        tag1[latchIdx]  <= latchTag;
      end else begin
        data0[latchIdx] <= dataReadFromMem;
        tag0[latchIdx]  <= latchTag;
      end
    end
  end

endmodule

// File: tb/tb_instr_cache_2way.sv
// tb_instr_cache_2way
//   Directed bench for instr_cache_2way with default parameters
//   (OFF=4, IDX=2, TAG=10). A second instance with a 2-bit miss counter
//   shares the same stimulus to exercise counter saturation.
module tb_instr_cache_2way;

  logic         clk;
  logic         reset;
  logic         petFromProc;
  logic [15:0]  virt_address;
  logic [9:0]   phys_tag;
  logic         flush;
  logic         memServiceReady;
  logic [255:0] dataReadFromMem;
  logic [15:0]  instructionBits;
  logic         isHit;
  logic [15:0]  addrToArb;
  logic         petitionToArb;
  logic         busy;
  logic [15:0]  missCount;

  logic [15:0]  sInstructionBits;
  logic         sIsHit;
  logic [15:0]  sAddrToArb;
  logic         sPetitionToArb;
  logic         sBusy;
  logic [1:0]   sMissCount;

  int checks;
  int failures;

  instr_cache_2way dut (
    .clk             (clk),
    .reset           (reset),
    .petFromProc     (petFromProc),
    .virt_address    (virt_address),
    .phys_tag        (phys_tag),
    .flush           (flush),
    .memServiceReady (memServiceReady),
    .dataReadFromMem (dataReadFromMem),
    .instructionBits (instructionBits),
    .isHit           (isHit),
    .addrToArb       (addrToArb),
    .petitionToArb   (petitionToArb),
    .busy            (busy),
    .missCount       (missCount)
  );

  instr_cache_2way #(.cnt_width(2)) dutSmall (
    .clk             (clk),
    .reset           (reset),
    .petFromProc     (petFromProc),
    .virt_address    (virt_address),
    .phys_tag        (phys_tag),
    .flush           (flush),
    .memServiceReady (memServiceReady),
    .dataReadFromMem (dataReadFromMem),
    .instructionBits (sInstructionBits),
    .isHit           (sIsHit),
    .addrToArb       (sAddrToArb),
    .petitionToArb   (sPetitionToArb),
    .busy            (sBusy),
    .missCount       (sMissCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] makeLine(input logic [15:0] base);
    logic [255:0] l;
    for (int w = 0; w < 16; w++) l[w*16 +: 16] = base + 16'(w);
    return l;
  endfunction

  // Combinational lookup with no request pending
  task automatic probe(input string tag, input logic [15:0] va, input logic [9:0] pt,
                       input logic expHit, input logic [15:0] expWord);
    petFromProc  = 1'b0;
    virt_address = va;
    phys_tag     = pt;
    #1;
    checkVal({tag, "_hit"}, 32'(isHit), 32'(expHit));
    checkVal({tag, "_word"}, 32'(instructionBits), 32'(expWord));
  endtask

  // Miss, one idle arbiter cycle, then the refill
  task automatic doMiss(input string tag, input logic [15:0] va, input logic [9:0] pt,
                        input logic [15:0] expAddr, input logic [15:0] expCnt,
                        input logic [15:0] base);
    petFromProc  = 1'b1;
    virt_address = va;
    phys_tag     = pt;
    #1;
    checkVal({tag, "_missLookup"}, 32'(isHit), 32'd0);
    tick();
    petFromProc = 1'b0;
    checkVal({tag, "_pet"}, 32'(petitionToArb), 32'd1);
    checkVal({tag, "_busy"}, 32'(busy), 32'd1);
    checkVal({tag, "_addr"}, 32'(addrToArb), 32'(expAddr));
    checkVal({tag, "_cnt"}, 32'(missCount), 32'(expCnt));
    tick();
    checkVal({tag, "_petHeld"}, 32'(petitionToArb), 32'd1);
    memServiceReady = 1'b1;
    dataReadFromMem = makeLine(base);
    tick();
    memServiceReady = 1'b0;
    checkVal({tag, "_petDone"}, 32'(petitionToArb), 32'd0);
    checkVal({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    petFromProc     = 1'b0;
    virt_address    = '0;
    phys_tag        = '0;
    flush           = 1'b0;
    memServiceReady = 1'b0;
    dataReadFromMem = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    checkVal("rst_hit", 32'(isHit), 32'd0);
    checkVal("rst_word", 32'(instructionBits), 32'd0);
    checkVal("rst_pet", 32'(petitionToArb), 32'd0);
    checkVal("rst_addr", 32'(addrToArb), 32'd0);
    checkVal("rst_cnt", 32'(missCount), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);

    // memServiceReady in IDLE must not fill anything
    virt_address    = 16'h0023;
    phys_tag        = 10'h005;
    memServiceReady = 1'b1;
    dataReadFromMem = makeLine(16'h1234);
    tick();
    memServiceReady = 1'b0;
    checkVal("idleReady_busy", 32'(busy), 32'd0);
    probe("idleReady", 16'h0023, 10'h005, 1'b0, 16'h0000);

    // First miss: set 2, offset 3, tag 0x05; victim is way 0
    doMiss("m1", 16'h0023, 10'h005, 16'h0160, 16'd1, 16'hBEEC);
    checkVal("m1_small", 32'(sMissCount), 32'd1);
    probe("m1_w3", 16'h0023, 10'h005, 1'b1, 16'hBEEF);
    probe("m1_w0", 16'h0020, 10'h005, 1'b1, 16'hBEEC);

    // Second miss in set 2, tag 0x09 goes into the empty way 1
    doMiss("m2", 16'h0021, 10'h009, 16'h0260, 16'd2, 16'h9000);
    probe("m2_a", 16'h0023, 10'h005, 1'b1, 16'hBEEF);
    probe("m2_b", 16'h0021, 10'h009, 1'b1, 16'h9001);
    probe("otherSet", 16'h0013, 10'h005, 1'b0, 16'h0000);

    // Hit on 0x05 makes way 1 (0x09) the LRU victim
    petFromProc  = 1'b1;
    virt_address = 16'h0023;
    phys_tag     = 10'h005;
    tick();
    petFromProc = 1'b0;
    checkVal("hitNoMiss_busy", 32'(busy), 32'd0);
    doMiss("m3", 16'h002F, 10'h00C, 16'h0320, 16'd3, 16'hC000);
    checkVal("m3_small", 32'(sMissCount), 32'd3);
    probe("lru_keep05", 16'h0023, 10'h005, 1'b1, 16'hBEEF);
    probe("lru_new0C", 16'h002F, 10'h00C, 1'b1, 16'hC00F);
    probe("lru_evict09", 16'h0021, 10'h009, 1'b0, 16'h0000);

    // Flush with a missing request present: nothing starts, everything invalid
    flush        = 1'b1;
    petFromProc  = 1'b1;
    virt_address = 16'h0001;
    phys_tag     = 10'h3FF;
    tick();
    flush       = 1'b0;
    petFromProc = 1'b0;
    checkVal("flush_busy", 32'(busy), 32'd0);
    checkVal("flush_pet", 32'(petitionToArb), 32'd0);
    checkVal("flush_cnt", 32'(missCount), 32'd3);
    probe("flush_05", 16'h0023, 10'h005, 1'b0, 16'h0000);
    probe("flush_0C", 16'h002F, 10'h00C, 1'b0, 16'h0000);

    // Flush together with memServiceReady aborts the refill
    petFromProc  = 1'b1;
    virt_address = 16'h0023;
    phys_tag     = 10'h005;
    tick();
    petFromProc = 1'b0;
    checkVal("abort_pet", 32'(petitionToArb), 32'd1);
    checkVal("abort_cnt", 32'(missCount), 32'd4);
    checkVal("abort_small", 32'(sMissCount), 32'd3);
    flush           = 1'b1;
    memServiceReady = 1'b1;
    dataReadFromMem = makeLine(16'h1110);
    tick();
    flush           = 1'b0;
    memServiceReady = 1'b0;
    checkVal("abort_petDone", 32'(petitionToArb), 32'd0);
    checkVal("abort_idle", 32'(busy), 32'd0);
    probe("abort_lookup", 16'h0023, 10'h005, 1'b0, 16'h0000);

    // Inputs change during MISS; the latched address must hold
    petFromProc  = 1'b1;
    virt_address = 16'h0037;
    phys_tag     = 10'h3AB;
    tick();
    petFromProc  = 1'b0;
    virt_address = 16'h0010;
    phys_tag     = 10'h001;
    checkVal("hold_addr0", 32'(addrToArb), 32'hEAF0);
    tick();
    checkVal("hold_addr1", 32'(addrToArb), 32'hEAF0);
    checkVal("hold_pet", 32'(petitionToArb), 32'd1);
    memServiceReady = 1'b1;
    dataReadFromMem = makeLine(16'h7770);
    tick();
    memServiceReady = 1'b0;
    checkVal("hold_cnt", 32'(missCount), 32'd5);
    checkVal("hold_small", 32'(sMissCount), 32'd3);
    probe("hold_orig", 16'h0037, 10'h3AB, 1'b1, 16'h7777);
    probe("hold_changed", 16'h0010, 10'h001, 1'b0, 16'h0000);

    // Reset during MISS: immediate abort, line not written
    petFromProc  = 1'b1;
    virt_address = 16'h0000;
    phys_tag     = 10'h002;
    tick();
    petFromProc = 1'b0;
    checkVal("rstMiss_busy", 32'(busy), 32'd1);
    memServiceReady = 1'b1;
    dataReadFromMem = makeLine(16'h5550);
    reset           = 1'b1;
    virt_address    = 16'h0037;
    phys_tag        = 10'h3AB;
    #1;
    checkVal("rstMiss_pet", 32'(petitionToArb), 32'd0);
    checkVal("rstMiss_idle", 32'(busy), 32'd0);
    checkVal("rstMiss_cnt", 32'(missCount), 32'd0);
    checkVal("rstMiss_hit", 32'(isHit), 32'd0);
    checkVal("rstMiss_word", 32'(instructionBits), 32'd0);
    tick();
    reset           = 1'b0;
    memServiceReady = 1'b0;
    probe("rstMiss_lookup", 16'h0000, 10'h002, 1'b0, 16'h0000);
    probe("rstMiss_old", 16'h0037, 10'h3AB, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_cache_2way.md
Name: instr_cache_2way

Overview:
- Parametrised successor to the direct-mapped fetch-stage instruction cache.
- 2-way set-associative, per-set LRU replacement, registered miss FSM toward the memory arbiter, flush (invalidate-all) input, saturating miss counter.
- Sits between fetch/TLB (virtual index and offset, physical tag) and the memory arbiter. Read-only; no write path from the processor.

Parameters:
- cache_line_width, 256, bits per line; a multiple of word_width.
- word_width, 16, instruction width in bits; addresses are word addresses.
- addr_width, 16, word-address width.
- num_sets, 4, sets per way; a power of two, at least 2.
- cnt_width, 16, miss counter width.
- Derived values:
  - OFF = log2(cache_line_width/word_width)
  - IDX = log2(num_sets)
  - TAG = addr_width-OFF-IDX

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- petFromProc  in  1  fetch request valid.
- virt_address  in  addr_width  bits [OFF+IDX-1:0] used as offset and index.
- phys_tag  in  TAG  translated tag from the TLB.
- flush  in  1  invalidate all lines.
- memServiceReady  in  1  arbiter: dataReadFromMem is valid this cycle.
- dataReadFromMem  in  cache_line_width  refill line; word w sits at bits [w*word_width +: word_width].
- instructionBits  out  word_width  selected word of the hitting way; 0 when there is no hit.
- isHit  out  1  combinational lookup hit.
- addrToArb  out  addr_width  {latched tag, latched index, OFF zeros}.
- petitionToArb  out  1  registered refill request.
- busy  out  1  FSM in MISS.
- missCount  out  cnt_width  saturating count of misses.

Behaviour:
- Reset (asynchronous, immediate):
  - all valid bits 0, LRU bits 0, state IDLE.
  - petitionToArb 0, addrToArb 0, missCount 0.
  - isHit 0 and instructionBits 0 while reset is high.
- Storage: per way and set, a data line, a TAG-bit tag and a valid bit. One LRU bit per set names the least-recently-used way.
- Lookup (combinational, every cycle, any state):
  - hit_w = valid[w][idx] && tag[w][idx]==phys_tag.
  - isHit = hit_0 | hit_1.
  - Both ways hitting cannot occur, because a fill never duplicates a tag; if it does, way 0 wins.
- FSM states are IDLE and MISS.
- IDLE:
  - petFromProc && isHit && !flush: LRU[idx] <= other way than the hit way.
  - petFromProc && !isHit && !flush:
    - latch idx, phys_tag and victim.
    - victim is way 0 if invalid, else way 1 if invalid, else LRU[idx].
    - go to MISS; petitionToArb <= 1; missCount += 1, saturating at all-ones.
  - flush: clear all valid and LRU bits; no miss is started that cycle.
- MISS:
  - petitionToArb is held at 1 and addrToArb is stable; both come from latched values, so virt_address and phys_tag may change.
  - memServiceReady && !flush:
    - write dataReadFromMem, the latched tag and valid=1 into victim[latched idx].
    - LRU[latched idx] <= other way than the victim.
    - go to IDLE; petitionToArb <= 0.
    - Earliest hit on the refilled address is the next cycle (miss-to-hit latency = arbiter latency + 1).
  - flush, with or without memServiceReady: abort. Clear all valid and LRU bits, no fill, go to IDLE, petitionToArb <= 0.
  - petFromProc dropping during MISS does not cancel the refill.
- Refill has priority over a simultaneous hit-LRU update; none can occur, because hits only update LRU in IDLE.
- memServiceReady while in IDLE is ignored.
- Reset asserted in MISS aborts immediately; the line is not written.
- missCount is never cleared by flush.

Test Plan:
- Reset, then petFromProc with virt_address=0x0023, phys_tag=0x05 (defaults: OFF=4, IDX=2, TAG=10):
  - isHit=0; next cycle petitionToArb=1, addrToArb=0x0160, missCount=1.
  - memServiceReady with line word3=0xBEEF: next cycle isHit=1 and instructionBits=0xBEEF for offset 3.
- Fill set 2 with tag 0x05 then tag 0x09 (two misses): both hit afterwards; missCount=2.
- Access tag 0x05 (a hit), then miss on tag 0x0C in set 2: way holding 0x09 is evicted; 0x05 and 0x0C hit, 0x09 misses.
- Pulse flush after fills: every previous address misses next cycle; missCount is unchanged.
- Start a miss, assert flush together with memServiceReady: petitionToArb=0 next cycle, state IDLE, address still misses.
- Miss, change virt_address and phys_tag while in MISS, then memServiceReady: addrToArb stayed at the original value; the original address hits after the fill.
